// File: rtl/call_stack_if.sv
// call_stack_if: decoder-side bus for the return-address stack.
interface call_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  modport master (output push, pop, flush, err_clr, data,
                  input  out, count, empty, full, ovf, unf);
  modport slave  (input  push, pop, flush, err_clr, data,
                  output out, count, empty, full, ovf, unf);
endinterface

// File: rtl/call_stack.sv
// call_stack: circular-buffer return-address stack with occupancy and sticky overflow/underflow flags.
module call_stack #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  call_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_tp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic [PW-1:0]    w_nxt;
  logic [PW-1:0]    w_prv;
  logic             w_empty;
  logic             w_full;
  logic             w_ovf_set;
  logic             w_unf_set;
  // explicit wrap so non-power-of-two depths index correctly
  assign w_nxt     = (r_tp == LAST) ? '0 : r_tp + PW'(1);
  assign w_prv     = (r_tp == '0) ? LAST : r_tp - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULLC);
  assign w_ovf_set = !bus.flush && bus.push && !bus.pop && w_full;
  assign w_unf_set = !bus.flush && bus.pop && !bus.push && w_empty;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_tp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !bus.err_clr) || w_ovf_set;
      r_unf <= (r_unf && !bus.err_clr) || w_unf_set;
      if (bus.flush) begin
        r_cnt <= '0;
        r_tp  <= '0;
      end else if (bus.push && bus.pop && !w_empty) begin
        r_mem[r_tp] <= bus.data;
      end else if (bus.push && (!w_full || OVF_MODE != 0)) begin
        r_mem[w_nxt] <= bus.data;
        r_tp         <= w_nxt;
        r_cnt        <= w_full ? r_cnt : r_cnt + CW'(1);
      end else if (bus.pop && !bus.push && !w_empty) begin
        r_tp  <= w_prv;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
  assign bus.out   = w_empty ? '0 : r_mem[r_tp];
  assign bus.count = r_cnt;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.ovf   = r_ovf;
  assign bus.unf   = r_unf;
endmodule

// File: doc/call_stack.md
# call_stack

Parametrised return-address stack: the successor to the single-entry link register in the CPU control path. It holds up to DEPTH return addresses so CALL/RET can nest, and it reports occupancy, full/empty and sticky overflow/underflow errors. It sits between the program counter output (push data) and the jump address mux (top-of-stack). The instruction decoder drives it through push/pop strobes.

## Interface
- WIDTH, 8: address/data width in bits.
- DEPTH, 4: number of entries; legal range 2..64, need not be a power of two.
- OVF_MODE, 0: full-stack push policy. 0 = reject the push; 1 = overwrite the oldest entry.
- CW, $clog2(DEPTH+1): width of count (localparam).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- push  in  1  push data this cycle (CALL)
- pop  in  1  pop top entry this cycle (RET)
- flush  in  1  synchronous clear of the stack (CPU soft reset)
- err_clr  in  1  synchronous clear of the ovf/unf sticky flags
- data  in  WIDTH  address to push
- out  out  WIDTH  top-of-stack; 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  sticky: a push was made while full
- unf  out  1  sticky: a pop was made while empty

## Operation
- Storage is a circular buffer of DEPTH×WIDTH registers, indexed by a top pointer tp.
  - tp advances on push and retreats on pop.
  - tp wraps explicitly: DEPTH-1 → 0 on advance, 0 → DEPTH-1 on retreat. No reliance on power-of-two truncation.
- Per-cycle priority: flush > {push, pop}. Flush sets count=0 and tp=0. Entry contents are don't-care after flush.
- push=1, pop=0:
  - Not full: write data at the next slot, tp advances, count+1.
  - Full, OVF_MODE=0: no state change; ovf←1.
  - Full, OVF_MODE=1: write at the next slot, overwriting the oldest entry; tp advances; count stays DEPTH; ovf←1.
- push=0, pop=1:
  - Not empty: tp retreats, count-1.
  - Empty: no state change; unf←1.
- push=1, pop=1 (tail call, replace top):
  - Not empty: overwrite the top entry with data; count and tp unchanged; no error.
  - Empty: behaves as a plain push; count=1; unf is not set.
- Flags:
  - ovf/unf set only in the cases above.
  - err_clr clears them, but a set condition in the same cycle wins (flag ends at 1).
  - flush does not clear ovf/unf.
- Outputs:
  - out = entry[tp] when count>0, else 0.
  - empty, full and out are combinational from registered state only. There is no combinational path from push/pop/data to any output.

## Timing
- Async reset (rst=0): count=0, tp=0, all entries=0, ovf=0, unf=0, so out=0, empty=1, full=0.
  - Takes effect immediately, mid-cycle, regardless of clk.
  - Release is sampled at the next rising edge. The first operation is accepted on the first edge with rst=1.
- All updates occur on the rising clk edge. A value pushed at edge N is visible on out after edge N.
- A pop at edge N exposes the previous entry on out after edge N. The popped value itself is read by the jump logic from out before edge N (zero-latency RET).
- One push or pop per cycle. Back-to-back operations on consecutive cycles are supported with no bubble.
- Reset asserted during any operation discards it; no partial write may be visible.

## Test plan
- Reset and basic LIFO (WIDTH=8, DEPTH=4): release reset; push 0x10, 0x20, 0x30 on consecutive cycles → out=0x30, count=3. Pop ×3 → out 0x20, 0x10, 0x00; empty=1; ovf=unf=0.
- Overflow, OVF_MODE=0: push 0x01..0x04 → full=1. Push 0x05 → out=0x04, count=4, ovf=1. Pop ×4 → 0x03, 0x02, 0x01, then empty.
- Overflow, OVF_MODE=1: push 0x01..0x05 → out=0x05, count=4, ovf=1. Pop ×3 → out 0x04, 0x03, 0x02; fourth pop → empty (0x01 lost).
- Underflow and flag clear: pop while empty → unf=1, count=0, out=0. Assert err_clr and pop-while-empty in the same cycle → unf stays 1. Assert err_clr alone → unf=0.
- Simultaneous ops: push 0xA0, then push+pop with 0xB0 → out=0xB0, count=1. From empty, push+pop with 0xC0 → count=1, out=0xC0, unf=0. flush together with push → count=0, out=0.
- Async reset mid-stream: with count=3, drop rst between clock edges → out=0, empty=1, ovf=unf=0 before the next edge. Repeat with DEPTH=5 to check non-power-of-two wrap using 7 pushes in OVF_MODE=1.
